// File: rtl/qdr_cmd_pkg.sv
// Shared types and constants for the QDR fabric command buffer.
// Defines the command-entry layout and default geometry.
package qdr_cmd_pkg;

    localparam int unsigned QDR_ADDR_WIDTH      = 32;
    localparam int unsigned DEF_QDR_DATA_WIDTH  = 36;
    localparam int unsigned DEF_QDR_BW_WIDTH    = 2;
    localparam int unsigned DEF_FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned DEF_MAX_RD_OUTSTANDING = 16;

    // Command entry with default widths; modules with other widths
    // declare a matching local struct of cmd_entry_width() bits.
    typedef struct packed {
        logic                            wr;
        logic                            rd;
        logic [QDR_ADDR_WIDTH-1:0]       addr;
        logic [2*DEF_QDR_DATA_WIDTH-1:0] data;
        logic [2*DEF_QDR_BW_WIDTH-1:0]   be;
    } qdr_cmd_t;

    function automatic int unsigned cmd_entry_width(input int unsigned data_width,
                                                    input int unsigned bw_width);
        return 2 + QDR_ADDR_WIDTH + 2 * data_width + 2 * bw_width;
    endfunction

endpackage

// File: rtl/qdr_cmd_fifo_mem.sv
// Show-ahead register FIFO: head entry is visible combinationally while
// not empty. Synchronous flush clears count and pointers.
module qdr_cmd_fifo_mem #(
    parameter int unsigned WIDTH      = 110,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  qdr_clk,
    input  logic                  qdr_rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]        mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]     count_reg, count_next;
    logic                    push_ok, pop_ok;

    assign full      = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge qdr_clk) begin
        if (push_ok && !flush)
            mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/qdr_cmd_buffer.sv
// Fabric-side command buffer feeding the QDR sniffer slave port.
// Optional statistics counters are enabled with QDR_CMD_BUFFER_STATS_EN.
module qdr_cmd_buffer
    import qdr_cmd_pkg::*;
#(
    parameter int unsigned QDR_DATA_WIDTH     = DEF_QDR_DATA_WIDTH,
    parameter int unsigned QDR_BW_WIDTH       = DEF_QDR_BW_WIDTH,
    parameter int unsigned FIFO_DEPTH_LOG2    = DEF_FIFO_DEPTH_LOG2,
    parameter int unsigned MAX_RD_OUTSTANDING = DEF_MAX_RD_OUTSTANDING
) (
    input  logic                          qdr_clk,
    input  logic                          qdr_rst_n,
    input  logic [31:0]                   fab_addr,
    input  logic                          fab_wr_strb,
    input  logic [2*QDR_DATA_WIDTH-1:0]   fab_wr_data,
    input  logic [2*QDR_BW_WIDTH-1:0]     fab_wr_be,
    input  logic                          fab_rd_strb,
    input  logic                          fab_flush,
    output logic                          fab_full,
    output logic                          fab_overflow,
    output logic                          fab_rd_err,
    output logic [2*QDR_DATA_WIDTH-1:0]   fab_rd_data,
    output logic                          fab_rd_dvld,
    output logic [31:0]                   slave_addr,
    output logic                          slave_wr_strb,
    output logic [2*QDR_DATA_WIDTH-1:0]   slave_wr_data,
    output logic [2*QDR_BW_WIDTH-1:0]     slave_wr_be,
    output logic                          slave_rd_strb,
    input  logic [2*QDR_DATA_WIDTH-1:0]   slave_rd_data,
    input  logic                          slave_rd_dvld,
    input  logic                          slave_ack
`ifdef QDR_CMD_BUFFER_STATS_EN
    ,
    output logic [31:0]                   stat_wr_cnt,
    output logic [31:0]                   stat_rd_cnt,
    output logic [31:0]                   stat_ack_stall_cnt
`endif
);

    localparam int unsigned DW2     = 2 * QDR_DATA_WIDTH;
    localparam int unsigned BW2     = 2 * QDR_BW_WIDTH;
    localparam int unsigned ENTRY_W = cmd_entry_width(QDR_DATA_WIDTH, QDR_BW_WIDTH);
    localparam int unsigned OUT_W   = $clog2(MAX_RD_OUTSTANDING + 1);

    typedef struct packed {
        logic                      wr;
        logic                      rd;
        logic [QDR_ADDR_WIDTH-1:0] addr;
        logic [DW2-1:0]            data;
        logic [BW2-1:0]            be;
    } cmd_entry_t;

    cmd_entry_t                 push_entry;
    cmd_entry_t                 head_entry;
    logic [ENTRY_W-1:0]         head_bits;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count;
    logic                       fifo_full, fifo_empty;
    logic                       push_req, push, pop, presented, rd_stall, rd_issue;

    logic [OUT_W-1:0]           rd_out_reg, rd_out_next;
    logic                       overflow_reg, rd_err_reg;
    logic [DW2-1:0]             rd_data_reg;
    logic                       rd_dvld_reg;
    logic [31:0]                addr_hold_reg;
    logic [DW2-1:0]             data_hold_reg;
    logic [BW2-1:0]             be_hold_reg;

    assign push_req   = fab_wr_strb | fab_rd_strb;
    assign push       = push_req & ~fifo_full & ~fab_flush;
    assign push_entry = '{wr: fab_wr_strb, rd: fab_rd_strb, addr: fab_addr,
                          data: fab_wr_data, be: fab_wr_be};

    qdr_cmd_fifo_mem #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .qdr_clk   (qdr_clk),
        .qdr_rst_n (qdr_rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (fab_flush),
        .head_data (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_entry = cmd_entry_t'(head_bits);

    // A combined wr+rd head stalls as a unit when the read budget is spent.
    assign rd_stall  = head_entry.rd & (rd_out_reg == OUT_W'(MAX_RD_OUTSTANDING));
    assign presented = ~fifo_empty & (head_entry.wr | head_entry.rd) & ~rd_stall;
    assign pop       = presented & slave_ack;
    assign rd_issue  = pop & head_entry.rd;

    assign slave_wr_strb = ~fifo_empty & head_entry.wr & ~rd_stall;
    assign slave_rd_strb = ~fifo_empty & head_entry.rd & ~rd_stall;
    assign slave_addr    = fifo_empty ? addr_hold_reg : head_entry.addr;
    assign slave_wr_data = fifo_empty ? data_hold_reg : head_entry.data;
    assign slave_wr_be   = fifo_empty ? be_hold_reg   : head_entry.be;

    assign fab_full     = fifo_full;
    assign fab_overflow = overflow_reg;
    assign fab_rd_err   = rd_err_reg;
    assign fab_rd_data  = rd_data_reg;
    assign fab_rd_dvld  = rd_dvld_reg;

    always_comb begin
        rd_out_next = rd_out_reg;
        if (rd_issue && !slave_rd_dvld)
            rd_out_next = rd_out_reg + 1'b1;
        else if (!rd_issue && slave_rd_dvld && rd_out_reg != '0)
            rd_out_next = rd_out_reg - 1'b1;
    end

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            rd_out_reg    <= '0;
            overflow_reg  <= 1'b0;
            rd_err_reg    <= 1'b0;
            rd_data_reg   <= '0;
            rd_dvld_reg   <= 1'b0;
            addr_hold_reg <= '0;
            data_hold_reg <= '0;
            be_hold_reg   <= '0;
        end else begin
            rd_out_reg  <= rd_out_next;
            rd_dvld_reg <= slave_rd_dvld;
            if (slave_rd_dvld)
                rd_data_reg <= slave_rd_data;
            if (push_req && fifo_full && !fab_flush)
                overflow_reg <= 1'b1;
            if (slave_rd_dvld && rd_out_reg == '0)
                rd_err_reg <= 1'b1;
            // Remember the last head so addr/data/be hold once empty.
            if (!fifo_empty) begin
                addr_hold_reg <= head_entry.addr;
                data_hold_reg <= head_entry.data;
                be_hold_reg   <= head_entry.be;
            end
        end
    end

`ifdef QDR_CMD_BUFFER_STATS_EN
    logic [31:0] stat_wr_cnt_reg, stat_rd_cnt_reg, stat_ack_stall_cnt_reg;

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            stat_wr_cnt_reg        <= '0;
            stat_rd_cnt_reg        <= '0;
            stat_ack_stall_cnt_reg <= '0;
        end else begin
            if (pop && head_entry.wr)
                stat_wr_cnt_reg <= stat_wr_cnt_reg + 1'b1;
            if (rd_issue)
                stat_rd_cnt_reg <= stat_rd_cnt_reg + 1'b1;
            if (presented && !slave_ack)
                stat_ack_stall_cnt_reg <= stat_ack_stall_cnt_reg + 1'b1;
        end
    end

    assign stat_wr_cnt        = stat_wr_cnt_reg;
    assign stat_rd_cnt        = stat_rd_cnt_reg;
    assign stat_ack_stall_cnt = stat_ack_stall_cnt_reg;
`endif

endmodule
